// File: rtl/regfile_dump_reader.sv
// Debug reader that walks the register file read port and streams
// {index,data} beats over a valid/ready link, one register per READ/SEND pair.
module regfile_dump_reader #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int FIRST_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_sel,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_index,
  output logic [DATA_W-1:0] m_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                valid_q, valid_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [DATA_W-1:0]   data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= FirstIdx;
      valid_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  // Abort beats everything, including a handshake landing in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    index_d = index_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          idx_d   = FirstIdx;
          state_d = READ;
        end
      end
      READ: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          data_d  = rd_data;
          index_d = idx_q;
          valid_d = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end else if (valid_q && m_ready) begin
          valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = READ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode straight from state so reset clears them at once.
  assign rd_sel  = (state_q == READ) || (state_q == SEND);
  assign rd_addr = rd_sel ? idx_q : '0;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE) && !abort;
  assign m_valid = valid_q;
  assign m_index = index_q;
  assign m_data  = data_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: one instance dumping from x0,
// a second one configured to skip x0.
module tb_regfile_dump_reader;

  logic        clk;
  logic        rst_n;
  logic        start0, abort0, m_ready0;
  logic        start1, abort1, m_ready1;
  logic [4:0]  rd_addr0, rd_addr1, m_index0, m_index1;
  logic [31:0] rd_data0, rd_data1, m_data0, m_data1;
  logic        rd_sel0, rd_sel1, m_valid0, m_valid1;
  logic        busy0, busy1, done0, done1;

  int vectors = 0;
  int miscompares = 0;
  int cycleNum = 0;
  int startCycle = 0;
  int beats0 = 0, beats1 = 0, dones0 = 0, dones1 = 0;
  int firstIdx1 = -1;
  logic [36:0] sb0[$];
  logic [36:0] sb1[$];

  function automatic logic [31:0] regVal(input logic [4:0] i);
    return {27'd0, i} * 32'h01010101;
  endfunction

  assign rd_data0 = regVal(rd_addr0);
  assign rd_data1 = regVal(rd_addr1);

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
    .rd_addr(rd_addr0), .rd_data(rd_data0), .rd_sel(rd_sel0),
    .m_valid(m_valid0), .m_ready(m_ready0), .m_index(m_index0), .m_data(m_data0),
    .busy(busy0), .done(done0)
  );

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .FIRST_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
    .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_sel(rd_sel1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_index(m_index1), .m_data(m_data1),
    .busy(busy1), .done(done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleNum++;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A beat counts as transferred only when valid&ready with no abort pending.
  always @(negedge clk) begin
    if (rst_n && m_valid0 && m_ready0 && !abort0) begin
      if (sb0.size() == 0) checkOutput("dut0 unexpected beat", {27'd0, m_index0, m_data0}, 64'd0);
      else checkOutput("dut0 beat", {27'd0, m_index0, m_data0}, {27'd0, sb0.pop_front()});
      beats0++;
    end
    if (rst_n && done0) dones0++;
    if (rst_n && m_valid1 && m_ready1 && !abort1) begin
      if (beats1 == 0) firstIdx1 = int'(m_index1);
      if (sb1.size() == 0) checkOutput("dut1 unexpected beat", {27'd0, m_index1, m_data1}, 64'd0);
      else checkOutput("dut1 beat", {27'd0, m_index1, m_data1}, {27'd0, sb1.pop_front()});
      beats1++;
    end
    if (rst_n && done1) dones1++;
  end

  task automatic applyStimulus(input int which);
    int first;
    first = (which == 0) ? 0 : 1;
    for (int i = first; i < 32; i++) begin
      if (which == 0) sb0.push_back({5'(i), regVal(5'(i))});
      else sb1.push_back({5'(i), regVal(5'(i))});
    end
    @(posedge clk); #1;
    if (which == 0) start0 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    startCycle = cycleNum;
  endtask

  task automatic waitDone(input int which, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if ((which == 0 && done0) || (which == 1 && done1)) begin
        seen = 1'b1;
        cyc = cycleNum - startCycle + 1;
      end
    end
    if (!seen) checkOutput("done timeout", 64'd0, 64'd1);
  endtask

  task automatic waitRead0(input int idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rd_sel0 && !m_valid0 && rd_addr0 == 5'(idx)) seen = 1'b1;
    end
    if (!seen) checkOutput("read wait timeout", 64'd0, 64'd1);
  endtask

  task automatic waitSend0(input int idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (m_valid0 && m_index0 == 5'(idx)) seen = 1'b1;
    end
    if (!seen) checkOutput("send wait timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cyc;
    int d0;
    rst_n = 1'b0;
    start0 = 1'b0; abort0 = 1'b0; m_ready0 = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; m_ready1 = 1'b1;
    #3;
    checkOutput("reset m_valid", 64'(m_valid0), 64'd0);
    checkOutput("reset busy", 64'(busy0), 64'd0);
    checkOutput("reset done", 64'(done0), 64'd0);
    checkOutput("reset rd_sel", 64'(rd_sel0), 64'd0);
    checkOutput("reset rd_addr", 64'(rd_addr0), 64'd0);
    checkOutput("reset m_index", 64'(m_index0), 64'd0);
    checkOutput("reset m_data", 64'(m_data0), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full dump with the sink always ready.
    beats0 = 0; d0 = dones0;
    applyStimulus(0);
    waitDone(0, cyc);
    checkOutput("t1 done cycle", 64'(cyc), 64'd65);
    @(negedge clk);
    checkOutput("t1 beats", 64'(beats0), 64'd32);
    checkOutput("t1 done pulses", 64'(dones0 - d0), 64'd1);
    checkOutput("t1 busy after", 64'(busy0), 64'd0);
    checkOutput("t1 sb empty", 64'(sb0.size()), 64'd0);

    // Backpressure on beat 3 for five cycles.
    beats0 = 0;
    applyStimulus(0);
    waitRead0(3);
    @(posedge clk); #1;
    m_ready0 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t2 stall valid", 64'(m_valid0), 64'd1);
      checkOutput("t2 stall beat", {27'd0, m_index0, m_data0}, {27'd0, 5'd3, 32'h03030303});
      @(posedge clk); #1;
    end
    m_ready0 = 1'b1;
    waitDone(0, cyc);
    checkOutput("t2 done cycle", 64'(cyc), 64'd70);
    @(negedge clk);
    checkOutput("t2 beats", 64'(beats0), 64'd32);

    // Second instance skips x0.
    beats1 = 0; firstIdx1 = -1; d0 = dones1;
    applyStimulus(1);
    waitDone(1, cyc);
    checkOutput("t3 done cycle", 64'(cyc), 64'd63);
    repeat (3) @(negedge clk);
    checkOutput("t3 beats", 64'(beats1), 64'd31);
    checkOutput("t3 first index", 64'(firstIdx1), 64'd1);
    checkOutput("t3 done pulses", 64'(dones1 - d0), 64'd1);
    checkOutput("t3 busy after", 64'(busy1), 64'd0);

    // Abort while beat 10 is being offered.
    beats0 = 0; d0 = dones0;
    applyStimulus(0);
    waitRead0(10);
    @(posedge clk); #1;
    abort0 = 1'b1;
    @(negedge clk);
    checkOutput("t4 valid at abort", 64'(m_valid0), 64'd1);
    @(posedge clk); #1;
    abort0 = 1'b0;
    @(negedge clk);
    checkOutput("t4 valid after", 64'(m_valid0), 64'd0);
    checkOutput("t4 busy after", 64'(busy0), 64'd0);
    checkOutput("t4 rd_sel after", 64'(rd_sel0), 64'd0);
    checkOutput("t4 beats", 64'(beats0), 64'd10);
    checkOutput("t4 pending", 64'(sb0.size()), 64'd22);
    sb0.delete();
    repeat (80) @(negedge clk);
    checkOutput("t4 no done", 64'(dones0 - d0), 64'd0);

    // A start during a dump is ignored.
    beats0 = 0; d0 = dones0;
    applyStimulus(0);
    waitSend0(5);
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    waitDone(0, cyc);
    checkOutput("t5 done cycle", 64'(cyc), 64'd65);
    @(negedge clk);
    checkOutput("t5 beats", 64'(beats0), 64'd32);
    checkOutput("t5 done pulses", 64'(dones0 - d0), 64'd1);

    // Reset mid SEND of beat 7, then a fresh dump.
    beats0 = 0; d0 = dones0;
    applyStimulus(0);
    waitSend0(7);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 valid in reset", 64'(m_valid0), 64'd0);
    checkOutput("t6 busy in reset", 64'(busy0), 64'd0);
    checkOutput("t6 rd_sel in reset", 64'(rd_sel0), 64'd0);
    checkOutput("t6 done in reset", 64'(done0), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb0.delete();
    checkOutput("t6 no done", 64'(dones0 - d0), 64'd0);
    beats0 = 0;
    applyStimulus(0);
    waitDone(0, cyc);
    checkOutput("t6 done cycle", 64'(cyc), 64'd65);
    @(negedge clk);
    checkOutput("t6 beats", 64'(beats0), 64'd32);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
